pwm_multichannel: RTL and testbench

Parametrised multi-channel PWM generator: successor to the single-channel 11-bit PWM. Shares one prescaled timebase across `CHANNELS` outputs, with a programmable period and edge- or center-aligned modes. Duty values are double-buffered so updates never glitch mid-period. Sits between the control register interface and the motor/LED drive pins.

---
 rtl/pwm_multichannel.sv | 114 +++++++++++
 tb/tb_pwm_multichannel.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator: one prescaled timebase, programmable period,
// edge- or center-aligned counting, double-buffered per-channel duty.
//
// state        | meaning
// running=0    | stopped or first enabled clock; next enabled edge is a period start
// running=1    | counting; dir selects up/down leg in center mode
// dir=DIR_UP   | counter incrementing (always the case in edge mode)
// dir=DIR_DOWN | center mode, counter decrementing toward the boundary
module pwm_multichannel #(
  parameter int WIDTH      = 11,
  parameter int CHANNELS   = 4,
  parameter int PRESCALE_W = 8,
  parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      period,
  input  logic                  center,
  input  logic                  wr_en,
  input  logic [CH_W-1:0]       wr_ch,
  input  logic [WIDTH-1:0]      wr_duty,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic                  cycle_start
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [CH_W:0]    CH_LIM = CHANNELS[CH_W:0];

  logic [PRESCALE_W-1:0] pre_cnt;
  logic [WIDTH-1:0]      cnt;
  dir_t                  dir;
  logic                  running;
  logic [WIDTH-1:0]      period_act;
  logic                  mode_act;
  logic [WIDTH-1:0]      duty_sh  [CHANNELS];
  logic [WIDTH-1:0]      duty_act [CHANNELS];

  logic tick;
  logic boundary;

  // Center mode with period 0 or 1 has no down leg, so the top itself closes the period.
  always_comb begin
    tick     = (pre_cnt == prescale);
    boundary = 1'b0;
    if (mode_act) begin
      if (dir == DIR_DOWN) boundary = tick && (cnt == ONE);
      else                 boundary = tick && (cnt == period_act) && (period_act <= ONE);
    end else begin
      boundary = tick && (cnt == period_act);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt     <= '0;
      cnt         <= '0;
      dir         <= DIR_UP;
      running     <= 1'b0;
      period_act  <= '0;
      mode_act    <= 1'b0;
      pwm_out     <= '0;
      cycle_start <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_sh[i]  <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      if (wr_en && ({1'b0, wr_ch} < CH_LIM)) duty_sh[wr_ch] <= wr_duty;

      if (!enable) begin
        running     <= 1'b0;
        pre_cnt     <= '0;
        cnt         <= '0;
        dir         <= DIR_UP;
        pwm_out     <= '0;
        cycle_start <= 1'b0;
        period_act  <= period;
        mode_act    <= center;
        duty_act    <= duty_sh;
      end else begin
        running <= 1'b1;
        pre_cnt <= (!running || tick) ? '0 : pre_cnt + 1'b1;
        for (int i = 0; i < CHANNELS; i++) pwm_out[i] <= running && (cnt < duty_act[i]);

        // The first enabled edge is treated as a boundary so the period restarts cleanly.
        if (!running || boundary) begin
          cnt         <= '0;
          dir         <= DIR_UP;
          period_act  <= period;
          mode_act    <= center;
          duty_act    <= duty_sh;
          cycle_start <= 1'b1;
        end else begin
          cycle_start <= 1'b0;
          if (tick) begin
            if (mode_act && (dir == DIR_UP) && (cnt == period_act)) begin
              dir <= DIR_DOWN;
              cnt <= cnt - 1'b1;
            end else if (mode_act && (dir == DIR_DOWN)) begin
              cnt <= cnt - 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Bench for pwm_multichannel: period-position model checked every cycle, plus
// directed scenarios with hand-computed high-time and cycle_start counts.
module tb_pwm_multichannel;
  localparam int W  = 11;
  localparam int N  = 4;
  localparam int PW = 8;

  logic          clk_in = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [PW-1:0] prescale;
  logic [W-1:0]  period;
  logic          center;
  logic          wr_en;
  logic [1:0]    wr_ch;
  logic [W-1:0]  wr_duty;
  logic [N-1:0]  pwm_out;
  logic          cycle_start;
  logic [2:0]    pwm3;
  logic          cs3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  pwm_multichannel #(.WIDTH(W), .CHANNELS(N), .PRESCALE_W(PW)) u_dut (
    .clk_in(clk_in), .rst_n(rst_n), .enable(enable), .prescale(prescale),
    .period(period), .center(center), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_duty(wr_duty), .pwm_out(pwm_out), .cycle_start(cycle_start)
  );

  // Three-channel copy: wr_ch==3 is out of range here and must be ignored.
  pwm_multichannel #(.WIDTH(W), .CHANNELS(3), .PRESCALE_W(PW)) u_dut3 (
    .clk_in(clk_in), .rst_n(rst_n), .enable(enable), .prescale(prescale),
    .period(period), .center(center), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_duty(wr_duty), .pwm_out(pwm3), .cycle_start(cs3)
  );

  // Model: position within the period (in ticks), counter value derived arithmetically.
  bit           m_run = 0;
  int           m_pre = 0;
  int           m_pos = 0;
  int           m_p   = 0;
  bit           m_c   = 0;
  int           m_c_v = 0;
  int           m_dact [N];
  int           m_dsh  [N];
  logic [N-1:0] exp_pwm = '0;
  logic         exp_cs  = 1'b0;

  function automatic int plen(input int p, input bit c);
    if (c) return (p == 0) ? 1 : 2 * p;
    return p + 1;
  endfunction

  function automatic int cnt_at(input int pos, input int p, input bit c);
    if (!c || pos <= p) return pos;
    return 2 * p - pos;
  endfunction

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_pre = 0; m_pos = 0; m_p = 0; m_c = 0;
      for (int i = 0; i < N; i++) begin m_dact[i] = 0; m_dsh[i] = 0; end
      exp_pwm = '0; exp_cs = 1'b0;
    end else begin
      if (!enable) begin
        m_run = 0; m_pre = 0; m_pos = 0;
        m_p = int'(period); m_c = center; m_dact = m_dsh;
        exp_pwm = '0; exp_cs = 1'b0;
      end else if (!m_run) begin
        m_run = 1; m_pre = 0; m_pos = 0;
        m_p = int'(period); m_c = center; m_dact = m_dsh;
        exp_pwm = '0; exp_cs = 1'b1;
      end else begin
        m_c_v = cnt_at(m_pos, m_p, m_c);
        for (int i = 0; i < N; i++) exp_pwm[i] = (m_c_v < m_dact[i]);
        exp_cs = 1'b0;
        if (m_pre == int'(prescale)) begin
          m_pre = 0;
          m_pos = m_pos + 1;
          if (m_pos == plen(m_p, m_c)) begin
            m_pos = 0; m_p = int'(period); m_c = center; m_dact = m_dsh;
            exp_cs = 1'b1;
          end
        end else begin
          m_pre = (m_pre + 1) % (1 << PW);
        end
      end
      if (wr_en) m_dsh[wr_ch] = int'(wr_duty);
    end
  end

  always @(negedge clk_in) begin
    n_vec++;
    if (pwm_out !== exp_pwm || cycle_start !== exp_cs) begin
      n_err++;
      $display("FAIL cycle_cmp t=%0t pwm_out=%b exp=%b cycle_start=%b exp=%b",
               $time, pwm_out, exp_pwm, cycle_start, exp_cs);
    end
    n_vec++;
    if (pwm3 !== exp_pwm[2:0] || cs3 !== exp_cs) begin
      n_err++;
      $display("FAIL cycle_cmp3 t=%0t pwm_out=%b exp=%b cycle_start=%b exp=%b",
               $time, pwm3, exp_pwm[2:0], cs3, exp_cs);
    end
  end

  int hi [N];
  int cs_cnt;
  int w  [4];
  int k;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic measure(input int n);
    cs_cnt = 0;
    for (int i = 0; i < N; i++) hi[i] = 0;
    repeat (n) begin
      @(negedge clk_in);
      for (int i = 0; i < N; i++) if (pwm_out[i]) hi[i]++;
      if (cycle_start) cs_cnt++;
    end
  endtask

  task automatic wait_cs(input string name, input int limit);
    int j;
    j = 0;
    do begin
      @(negedge clk_in);
      j++;
    end while (!cycle_start && j < limit);
    if (!cycle_start) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: cycle_start not seen within %0d clocks", name, limit);
    end
  endtask

  task automatic wr(input int ch, input int d);
    @(negedge clk_in);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_duty = W'(d);
    @(negedge clk_in);
    wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; center = 1'b0; wr_en = 1'b0;
    wr_ch = '0; wr_duty = '0; prescale = '0; period = '0;
    @(negedge clk_in);
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_cs", int'(cycle_start), 0);

    // Edge mode, period 9, duty 3 on ch0.
    rst_n = 1'b1; period = W'(9);
    wr(0, 3);
    @(negedge clk_in); enable = 1'b1;
    repeat (30) @(negedge clk_in);
    measure(20);
    check("p9d3_hi", hi[0], 6);
    check("p9d3_cs", cs_cnt, 2);

    // Asynchronous reset while ch0 is high.
    k = 0;
    while (!pwm_out[0] && k < 20) begin @(negedge clk_in); k++; end
    check("pre_rst_high", int'(pwm_out[0]), 1);
    #2 rst_n = 1'b0;
    #1 check("async_rst_pwm", int'(pwm_out), 0);
    @(negedge clk_in); @(negedge clk_in);
    rst_n = 1'b1;

    // Duty limits: 0, 5, 10 (> period), 2047.
    wr(0, 0); wr(1, 5); wr(2, 10); wr(3, 2047);
    repeat (30) @(negedge clk_in);
    measure(10);
    check("lim_d0", hi[0], 0);
    check("lim_d5", hi[1], 5);
    check("lim_d10", hi[2], 10);
    check("lim_d2047", hi[3], 10);
    check("lim_cs", cs_cnt, 1);

    // Center mode, period 4: 8-clock period, duty 2 high for 3 clocks.
    center = 1'b1; period = W'(4);
    wr(0, 2);
    repeat (30) @(negedge clk_in);
    measure(16);
    check("ctr_d2", hi[0], 6);
    check("ctr_d5", hi[1], 16);
    check("ctr_cs", cs_cnt, 2);

    // Prescaler 3, edge, period 4: 20-clock period, duty 2 high for 8.
    center = 1'b0; prescale = PW'(3);
    repeat (60) @(negedge clk_in);
    measure(40);
    check("pre_d2", hi[0], 16);
    check("pre_cs", cs_cnt, 2);

    // Shrinking prescale below the running prescaler count forces a wrap.
    prescale = PW'(200);
    repeat (100) @(negedge clk_in);
    prescale = PW'(3);
    repeat (300) @(negedge clk_in);

    // Double buffering: mid-period write, boundary-coincident write, out-of-range write.
    prescale = '0; period = W'(9);
    wr(1, 2);
    repeat (40) @(negedge clk_in);
    wait_cs("db_sync", 30);
    for (int i = 0; i < 4; i++) w[i] = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk_in);
      if (pwm_out[1]) w[(j - 1) / 10]++;
      wr_en = 1'b0;
      case (j)
        3:  begin wr_en = 1'b1; wr_ch = 2'd1; wr_duty = W'(7); end
        19: begin wr_en = 1'b1; wr_ch = 2'd1; wr_duty = W'(4); end
        25: begin wr_en = 1'b1; wr_ch = 2'd3; wr_duty = W'(0); end
        default: ;
      endcase
    end
    check("db_keep_old", w[0], 2);
    check("db_new", w[1], 7);
    check("db_coincident_old", w[2], 7);
    check("db_coincident_new", w[3], 4);

    // Enable toggle.
    repeat (5) @(negedge clk_in);
    enable = 1'b0;
    @(negedge clk_in);
    check("dis_pwm", int'(pwm_out), 0);
    check("dis_cs", int'(cycle_start), 0);
    period = W'(5);
    wr(0, 1);
    @(negedge clk_in); enable = 1'b1;
    @(negedge clk_in);
    check("en_cs_pulse", int'(cycle_start), 1);
    measure(12);
    check("en_d1", hi[0], 2);
    check("en_cs", cs_cnt, 2);

    // Full-range period: counter must reach 2047 and return to 0 without wrapping.
    period = W'(2047);
    wr(0, 2047); wr(1, 1024);
    repeat (20) @(negedge clk_in);
    wait_cs("wrap_sync", 2100);
    measure(2048);
    check("wrap_d2047", hi[0], 2047);
    check("wrap_d1024", hi[1], 1024);
    check("wrap_cs", cs_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
